byte_strip_lanes: RTL

// - Parametrised byte striper: takes one symbol/cycle (data + K flag) and deals it

---
 rtl/byte_strip_lanes.sv | 99 +++++++++
 1 files changed

// File: rtl/byte_strip_lanes.sv
// Round-robin symbol striper: deals one symbol per cycle across NUM_LANES lanes and
// presents each completed (or K-flushed, padded) group as one registered output word.
module byte_strip_lanes #(
    parameter int                NUM_LANES = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] PAD_SYM   = DATA_W'(8'h7C),
    parameter logic [DATA_W-1:0] FLUSH_SYM = DATA_W'(8'hFD),
    parameter bit                PAD_EN    = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DATA_W-1:0]           D,
    input  logic                        DK,
    input  logic                        D_VALID,
    output logic                        D_READY,
    output logic [NUM_LANES*DATA_W-1:0] LANES,
    output logic [NUM_LANES-1:0]        DK_LANES,
    output logic [NUM_LANES-1:0]        PAD_MASK,
    output logic                        LANES_VALID,
    input  logic                        LANES_READY
);

    localparam int               PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_LANES - 1);

    logic [PTR_W-1:0]            ptr;
    logic [DATA_W-1:0]           buf_d [NUM_LANES];
    logic [NUM_LANES-1:0]        buf_k;

    logic                        accept;
    logic                        at_last;
    logic                        flush;
    logic                        close;
    logic [NUM_LANES*DATA_W-1:0] grp_d;
    logic [NUM_LANES-1:0]        grp_k;
    logic [NUM_LANES-1:0]        grp_pad;

    // Input stalls only while a held group is not being taken this cycle.
    assign D_READY = !RESET && (!LANES_VALID || LANES_READY);
    assign accept  = D_VALID && D_READY;
    assign at_last = (ptr == LAST);
    assign flush   = PAD_EN && DK && (D == FLUSH_SYM) && !at_last;
    assign close   = accept && (at_last || flush);

    // Group as it would look if closed now: stored slots, the incoming symbol, then pads.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        grp_d   = '0;
        grp_k   = '0;
        grp_pad = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (k < int'(ptr)) begin
                grp_d[k*DATA_W +: DATA_W] = buf_d[k];
                grp_k[k]                  = buf_k[k];
            end else if (k == int'(ptr)) begin
                grp_d[k*DATA_W +: DATA_W] = D;
                grp_k[k]                  = DK;
            end else begin
                grp_d[k*DATA_W +: DATA_W] = PAD_SYM;
                grp_k[k]                  = 1'b1;
                grp_pad[k]                = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr         <= '0;
            buf_k       <= '0;
            // NOTE: the collect buffer is cleared too, so a discarded partial group leaves no stale symbols.
            for (int k = 0; k < NUM_LANES; k++) begin
                buf_d[k] <= '0;
            end
            LANES       <= '0;
            DK_LANES    <= '0;
            PAD_MASK    <= '0;
            LANES_VALID <= 1'b0;
        end else begin
            if (close) begin
                LANES       <= grp_d;
                DK_LANES    <= grp_k;
                PAD_MASK    <= grp_pad;
                LANES_VALID <= 1'b1;
                ptr         <= '0;
            end else begin
                if (LANES_VALID && LANES_READY) begin
                    LANES_VALID <= 1'b0;
                end
                if (accept) begin
                    buf_d[ptr] <= D;
                    buf_k[ptr] <= DK;
                    ptr        <= ptr + 1'b1;
                end
            end
        end
    end

endmodule
